// File: rtl/arp_if.sv
// arp_if: payload byte stream from the MAC receive path into the ARP parser.
interface arp_if;
  logic       in_valid;
  logic [7:0] din;
  logic       in_last;
  logic       in_error;
  modport master (output in_valid, din, in_last, in_error);
  modport slave (input in_valid, din, in_last, in_error);
endinterface

// File: rtl/arp_decode.sv
// arp_decode: parses an ARP payload, flags requests for IP_ADDR and captures SHA/SPA.
module arp_decode #(
  parameter logic [31:0] IP_ADDR = 32'h69696969
) (
  input  logic        clk,
  input  logic        rst,
  arp_if.slave        s,
  output logic        req_valid,
  output logic [47:0] sha,
  output logic [31:0] spa,
  output logic [15:0] drop_count
);
  localparam logic [63:0] HDR = 64'h0001_0800_0604_0001;
  typedef enum logic {PARSE, PAD} state_t;
  state_t      state;
  logic [4:0]  cnt;
  logic        ok;
  logic [47:0] sha_sh;
  logic [31:0] spa_sh;
  logic [7:0]  exp_byte;
  logic        chk, ok_now, accept;
  always_comb begin
    exp_byte = cnt < 5'd8 ? HDR[{~cnt[2:0], 3'b000} +: 8] : IP_ADDR[{~cnt[1:0], 3'b000} +: 8];
    chk      = state == PARSE && (cnt < 5'd8 || cnt >= 5'd24);
    ok_now   = ok && (!chk || s.din == exp_byte);
    accept   = ok_now && cnt >= 5'd27 && !s.in_error;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PARSE;
      cnt        <= '0;
      ok         <= 1'b1;
      sha_sh     <= '0;
      spa_sh     <= '0;
      req_valid  <= 1'b0;
      sha        <= '0;
      spa        <= '0;
      drop_count <= '0;
    end else begin
      req_valid <= 1'b0;
      if (s.in_valid && s.in_last) begin
        state <= PARSE;
        cnt   <= '0;
        ok    <= 1'b1;
        if (accept) begin
          req_valid <= 1'b1;
          sha       <= sha_sh;
          spa       <= spa_sh;
        end else begin
          drop_count <= drop_count + {15'd0, drop_count != 16'hFFFF};
        end
      end else if (s.in_valid) begin
        ok    <= ok_now;
        cnt   <= state == PAD ? cnt : cnt + 5'd1;
        state <= cnt == 5'd27 ? PAD : state;
        if (cnt >= 5'd8 && cnt < 5'd14) sha_sh <= {sha_sh[39:0], s.din};
        if (cnt >= 5'd14 && cnt < 5'd18) spa_sh <= {spa_sh[23:0], s.din};
      end
    end
  end
endmodule

// File: tb/tb_arp_decode.sv
// tb_arp_decode: random ARP frames against a byte-level reference model.
module tb_arp_decode;
  localparam logic [31:0] IP = 32'h69696969;
  logic        clk = 0;
  logic        rst = 1;
  logic        req_valid;
  logic [47:0] sha;
  logic [31:0] spa;
  logic [15:0] drop_count;
  arp_if bus();
  arp_decode dut (.clk(clk), .rst(rst), .s(bus), .req_valid(req_valid), .sha(sha), .spa(spa),
                  .drop_count(drop_count));
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0]  fr[$];
  logic        pend = 0;
  logic [47:0] esha = '0;
  logic [31:0] espa = '0;
  logic [15:0] edrop = '0;
  logic [47:0] rsha;
  logic [31:0] rspa;
  logic [7:0]  hdr[8] = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic v, input logic [7:0] d, input logic l, input logic e);
    @(negedge clk);
    chk("req_valid", {63'd0, req_valid}, {63'd0, pend});
    chk("sha", {16'd0, sha}, {16'd0, esha});
    chk("spa", {32'd0, spa}, {32'd0, espa});
    chk("drop_count", {48'd0, drop_count}, {48'd0, edrop});
    pend = 0;
    bus.in_valid = v;
    bus.din = d;
    bus.in_last = l;
    bus.in_error = e;
  endtask

  task automatic build(input logic [15:0] oper, input logic [31:0] tpa, input int pad);
    rsha = {$urandom, $urandom};
    rspa = $urandom;
    fr = {};
    for (int i = 0; i < 6; i++) fr.push_back(hdr[i]);
    fr.push_back(oper[15:8]);
    fr.push_back(oper[7:0]);
    for (int i = 5; i >= 0; i--) fr.push_back(rsha[8*i +: 8]);
    for (int i = 3; i >= 0; i--) fr.push_back(rspa[8*i +: 8]);
    for (int i = 0; i < 6; i++) fr.push_back(8'($urandom));
    for (int i = 3; i >= 0; i--) fr.push_back(tpa[8*i +: 8]);
    for (int i = 0; i < pad; i++) fr.push_back(8'($urandom));
  endtask

  task automatic send(input logic err, input int gmax);
    bit acc;
    logic [31:0] ip;
    ip = IP;
    acc = fr.size() >= 28 && !err;
    if (acc) begin
      for (int i = 0; i < 8; i++) if (fr[i] != hdr[i]) acc = 0;
      for (int i = 0; i < 4; i++) if (fr[24+i] != ip[8*(3-i) +: 8]) acc = 0;
    end
    for (int i = 0; i < fr.size(); i++) begin
      for (int g = $urandom_range(gmax); g > 0; g--) tick(0, 8'($urandom), 1'($urandom), 0);
      tick(1, fr[i], i == fr.size() - 1, i == fr.size() - 1 ? err : 1'($urandom));
    end
    if (acc) begin
      pend = 1;
      for (int i = 0; i < 6; i++) esha[8*(5-i) +: 8] = fr[8+i];
      for (int i = 0; i < 4; i++) espa[8*(3-i) +: 8] = fr[14+i];
    end else if (edrop != 16'hFFFF) edrop++;
  endtask

  initial begin
    bus.in_valid = 0;
    bus.din = 0;
    bus.in_last = 0;
    bus.in_error = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_req_valid", {63'd0, req_valid}, 64'd0);
    chk("rst_sha", {16'd0, sha}, 64'd0);
    chk("rst_spa", {32'd0, spa}, 64'd0);
    chk("rst_drop", {48'd0, drop_count}, 64'd0);
    build(16'h0001, IP, 18);
    rsha = 48'h021122334455;
    rspa = 32'hC0A80001;
    for (int i = 0; i < 6; i++) fr[8+i] = rsha[8*(5-i) +: 8];
    for (int i = 0; i < 4; i++) fr[14+i] = rspa[8*(3-i) +: 8];
    send(0, 0);
    tick(0, 0, 0, 0);
    chk("first_sha", {16'd0, sha}, 64'h021122334455);
    chk("first_spa", {32'd0, spa}, 64'hC0A80001);
    build(16'h0001, IP - 1, 18);
    send(0, 0);
    build(16'h0002, IP, 18);
    send(0, 0);
    tick(0, 0, 0, 0);
    chk("mismatch_drops", {48'd0, drop_count}, 64'd2);
    build(16'h0001, IP, 0);
    while (fr.size() > 21) void'(fr.pop_back());
    send(0, 0);
    build(16'h0001, IP, 5);
    send(0, 0);
    build(16'h0001, IP, 7);
    send(1, 0);
    build(16'h0001, IP, 18);
    send(0, 5);
    build(16'h0001, IP, 0);
    send(0, 0);
    build(16'h0001, IP, 18);
    send(0, 0);
    build(16'h0001, IP, 18);
    send(0, 0);
    build(16'h0001, IP, 240);
    send(0, 0);
    fr = {8'h00};
    send(0, 0);
    build(16'h0001, IP, 18);
    for (int i = 0; i < 12; i++) tick(1, fr[i], 0, 0);
    tick(0, 0, 0, 0);
    rst = 1;
    esha = '0;
    espa = '0;
    edrop = '0;
    tick(0, 0, 0, 0);
    rst = 0;
    build(16'h0001, IP, 3);
    send(0, 0);
    for (int n = 0; n < 30; n++) begin
      build($urandom_range(3) == 0 ? 16'h0002 : 16'h0001, $urandom_range(3) == 0 ? IP ^ 32'h100 : IP,
            $urandom_range(20));
      if ($urandom_range(4) == 0) fr[$urandom_range(7)] ^= 8'h10;
      if ($urandom_range(5) == 0) while (fr.size() > 27 - $urandom_range(1)) void'(fr.pop_back());
      send($urandom_range(6) == 0, $urandom_range(2));
    end
    repeat (3) tick(0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/arp_decode.md
# arp_decode

Receive-side ARP parser. Consumes the byte stream of an Ethernet frame payload (EtherType 0x0806 already matched, MAC header stripped upstream), checks that it is an Ethernet/IPv4 ARP request addressed to IP_ADDR, and captures the requester's hardware and protocol addresses. The resulting one-cycle request strobe plus captured SHA/SPA drive the transmit-side ARP reply encoder as its tha/tpa and start condition.

## Interface

- IP_ADDR, 32'h69696969, our IPv4 address; compared against TPA.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  din carries a payload byte this cycle.
- din  in  8  payload byte, network (MSB-first) order.
- in_last  in  1  qualified by in_valid; marks the final byte of the frame, including padding.
- in_error  in  1  qualified by in_valid & in_last; frame failed FCS or had a PHY error.
- req_valid  out  1  one-cycle pulse: a valid ARP request for IP_ADDR completed.
- sha  out  48  sender hardware address of the last accepted request.
- spa  out  32  sender protocol address of the last accepted request.
- drop_count  out  16  saturating count of frames that ended without a req_valid.

## Operation

- Byte offsets: 0-1 HTYPE (must be 0x0001), 2-3 PTYPE (0x0800), 4 HLEN (0x06), 5 PLEN (0x04), 6-7 OPER (0x0001, request), 8-13 SHA, 14-17 SPA, 18-23 THA (ignored), 24-27 TPA (must equal IP_ADDR).
- Bytes 28 and later are padding and are discarded until in_last.
- Byte counter: 5 bits. Starts at 0 and increments on each in_valid byte. Saturates at 28. Clears to 0 on the in_last beat.
- ok flag: set at frame start. Cleared on any byte at offsets 0-7 or 24-27 that differs from its expected value. Each comparison uses the byte's offset within the field, MSB first.
- Shadow registers capture SHA and SPA bytes at offsets 8-17. Shadow registers are not outputs.
- States:
  - PARSE: counter < 28.
  - PAD: counter == 28; wait for in_last.
  - Either state returns to PARSE with counter 0 on the in_last beat.
- On the in_last beat, accept iff all of:
  - ok is set, including a check of the current byte when it is byte 27;
  - the frame had at least 28 bytes, i.e. in_last fell on offset 27 or later;
  - in_error is 0.
- On accept: the next cycle pulses req_valid and loads sha/spa from the shadow registers.
- On any non-accept end of frame: no pulse, sha/spa unchanged, drop_count increments, saturating at 16'hFFFF. This covers short frames, field mismatch, reply opcode, TPA mismatch and in_error.
- sha/spa hold their value between accepted requests.

## Timing

- Reset values: req_valid=0, sha=0, spa=0, drop_count=0, counter=0, ok=1, shadow registers=0.
- Latency: req_valid and the new sha/spa appear exactly 1 cycle after the in_last beat. Both are registered outputs.
- in_valid may deassert for any number of cycles mid-frame. State holds and nothing is evaluated while in_valid=0.
- Back-to-back frames: a byte arriving in the cycle right after in_last is offset 0 of the next frame. This byte must be parsed correctly while the previous frame's req_valid is high.
- in_last on offset 0 (1-byte frame): counts as a drop; counter returns to 0.
- Counter saturation: frames longer than 255 bytes must not wrap the counter into PARSE.
- Reset mid-frame: all state clears. The next in_valid byte is treated as offset 0; upstream aligns reset with frame boundaries.
- drop_count at 16'hFFFF stays at 16'hFFFF on further drops.

## Test plan

- Valid request:
  - Stimulus: 28 bytes 00 01 08 00 06 04 00 01, SHA 02:11:22:33:44:55, SPA C0A80001, THA 00×6, TPA 69696969, followed by 18 pad bytes with in_last on the last one.
  - Response: req_valid pulses once, 1 cycle after in_last; sha=48'h021122334455, spa=32'hC0A80001; drop_count=0.
- Mismatches: same frame with TPA=69696968, then a separate frame with OPER=0x0002 → no req_valid; drop_count=2; sha/spa keep their previous values.
- Short frame: in_last on byte 20 → no pulse, drop_count+1. The next valid frame, started the cycle after that in_last, still produces req_valid.
- in_error=1 on the in_last beat of an otherwise valid frame → no pulse, drop_count+1.
- Gaps and boundaries:
  - Valid request with random in_valid gaps of 0-5 cycles → same response as the first scenario.
  - Exactly 28-byte frame with in_last on byte 27 → accepted.
- Back-to-back and reset:
  - Two valid requests with no idle cycle between them → two pulses exactly 28+pad cycles apart, each with correct sha/spa.
  - rst asserted at byte 12 of a frame → all outputs 0; a subsequent valid frame is accepted.
